// File: rtl/dac_spi_receiver.sv
// Receiver for dual-channel DAC write frames: deserialises cs_n/sdi, holds per-channel input
// registers and transfers them to the output registers while ldac_n is low.
module dac_spi_receiver #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned FRAME_W = DATA_W + 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_2MHz,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sdi,
  input  logic              ldac_n,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        cfg_a,
  output logic [2:0]        cfg_b,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned BitCntW = $clog2(FRAME_W + 1);
  localparam int unsigned RegW    = DATA_W + 3;
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(FRAME_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StFull} state_e;

  state_e             state;
  logic [FRAME_W-1:0] sr;
  logic [BitCntW-1:0] bit_cnt;
  // Input registers hold {cfg[2:0], code}
  logic [RegW-1:0]    inreg_a;
  logic [RegW-1:0]    inreg_b;

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      state      <= StIdle;
      sr         <= '0;
      bit_cnt    <= '0;
      inreg_a    <= '0;
      inreg_b    <= '0;
      out_a      <= '0;
      out_b      <= '0;
      cfg_a      <= '0;
      cfg_b      <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      // Samples the input registers before any commit on this edge lands
      if (!ldac_n) begin
        out_a <= inreg_a[DATA_W-1:0];
        cfg_a <= inreg_a[RegW-1:DATA_W];
        out_b <= inreg_b[DATA_W-1:0];
        cfg_b <= inreg_b[RegW-1:DATA_W];
      end

      unique case (state)
        StIdle: begin
          if (!cs_n) begin
            sr      <= {sr[FRAME_W-2:0], sdi};
            bit_cnt <= BitCntW'(1);
            state   <= StShift;
          end
        end
        StShift: begin
          if (!cs_n) begin
            sr      <= {sr[FRAME_W-2:0], sdi};
            bit_cnt <= bit_cnt + BitCntW'(1);
            if (bit_cnt == LastBit) begin
              state <= StFull;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= StIdle;
          end
        end
        StFull: begin
          // Surplus bits while cs_n stays low are dropped; sr is left untouched
          if (cs_n) begin
            if (sr[FRAME_W-1]) begin
              inreg_b <= sr[RegW-1:0];
            end else begin
              inreg_a <= sr[RegW-1:0];
            end
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + CNT_W'(1);
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Scoreboard bench for dac_spi_receiver: directed frames from the test plan followed by
// randomized frames of random length, checked against a frame-level model.
`timescale 1ns / 1ps
module tb_dac_spi_receiver;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 4;  // narrow counter so random frames exercise the wrap

  typedef struct packed {
    logic             err;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  logic              clk_2MHz = 1'b0;
  logic              reset;
  logic              cs_n;
  logic              sdi;
  logic              ldac_n;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        cfg_a;
  logic [2:0]        cfg_b;
  logic              frame_done;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_cnt;

  dac_spi_receiver #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_2MHz   (clk_2MHz),
    .reset      (reset),
    .cs_n       (cs_n),
    .sdi        (sdi),
    .ldac_n     (ldac_n),
    .out_a      (out_a),
    .out_b      (out_b),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  always #250 clk_2MHz = ~clk_2MHz;

  // Frame-level model: channel words {cfg, code} and valid-frame count
  logic [14:0]      m_a   = '0;
  logic [14:0]      m_b   = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  ev_t         ev_q[$];
  logic [29:0] out_q[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; an edge with ldac_n low copies the channel words as they stand before it
  task automatic tick();
    if (!ldac_n && !reset) out_q.push_back({m_a, m_b});
    @(posedge clk_2MHz);
    #1;
  endtask

  // mode: 0 no LDAC, 1 LDAC pulse after commit, 2 LDAC held low through frame and commit
  task automatic send_frame(input logic [15:0] word, input int nbits, input int mode,
                            input int gap);
    if (mode == 2) ldac_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      cs_n = 1'b0;
      sdi  = (i < 16) ? word[15-i] : 1'b1;
      tick();
    end
    cs_n = 1'b1;
    sdi  = 1'b0;
    tick();
    if (nbits >= 16) begin
      if (word[15]) m_b = word[14:0];
      else m_a = word[14:0];
      m_cnt = m_cnt + 1'b1;
      ev_q.push_back('{err: 1'b0, cnt: m_cnt});
    end else begin
      ev_q.push_back('{err: 1'b1, cnt: m_cnt});
    end
    if (mode != 0) begin
      ldac_n = 1'b0;
      tick();
    end
    ldac_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic abort_with_reset(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      cs_n = 1'b0;
      sdi  = word[15-i];
      tick();
    end
    cs_n  = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_a   = '0;
    m_b   = '0;
    m_cnt = '0;
  endtask

  // Monitor
  logic        mon_ldac = 1'b0;
  logic        mon_rst  = 1'b1;
  logic [29:0] exp_out  = '0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(posedge clk_2MHz) begin
    mon_ldac <= !ldac_n;
    mon_rst  <= reset;
  end

  always @(negedge clk_2MHz) begin
    ev_t ev;
    if (mon_rst) begin
      exp_out = '0;
      exp_cnt = '0;
      chk("pulse_in_reset", {30'd0, frame_done, frame_err}, 32'd0);
    end else begin
      if (mon_ldac) begin
        if (out_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL ldac_queue: got empty queue, expected an output value at %0t", $time);
        end else begin
          exp_out = out_q.pop_front();
        end
      end
      if (frame_done || frame_err) begin
        if (ev_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL spurious_pulse: got done=%0b err=%0b, expected none at %0t",
                   frame_done, frame_err, $time);
        end else begin
          ev = ev_q.pop_front();
          chk("pulse_kind", {30'd0, frame_done, frame_err}, {30'd0, !ev.err, ev.err});
          exp_cnt = ev.cnt;
        end
      end
    end
    chk("out_a", {20'd0, out_a}, {20'd0, exp_out[26:15]});
    chk("cfg_a", {29'd0, cfg_a}, {29'd0, exp_out[29:27]});
    chk("out_b", {20'd0, out_b}, {20'd0, exp_out[11:0]});
    chk("cfg_b", {29'd0, cfg_b}, {29'd0, exp_out[14:12]});
    chk("frame_cnt", {28'd0, frame_cnt}, {28'd0, exp_cnt});
  end

  initial begin
    logic [15:0] w;
    int          r;
    int          nb;
    reset  = 1'b1;
    cs_n   = 1'b1;
    sdi    = 1'b0;
    ldac_n = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    send_frame(16'h3ABC, 16, 1, 1);
    send_frame(16'h3123, 16, 0, 0);
    send_frame(16'hB456, 16, 1, 1);
    send_frame(16'h1FFF, 9, 1, 1);
    send_frame(16'h3800, 18, 1, 1);
    send_frame(16'h3055, 16, 2, 1);
    abort_with_reset(16'h5A5A, 8);
    send_frame(16'hB7FF, 16, 1, 2);

    for (int k = 0; k < 60; k++) begin
      w = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3) nb = $urandom_range(1, 15);
      else if (r < 8) nb = 16;
      else nb = $urandom_range(17, 19);
      send_frame(w, nb, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (3) tick();
    chk("events_drained", ev_q.size(), 32'd0);
    chk("ldac_drained", out_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
